// File: rtl/riscv_fetch_pkg.sv
// Shared types and widths for the instruction-fetch front end.
package riscv_fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is readable without a pop.
module prefetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok  = pop && (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && ((count_q != FULL_CNT) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/prefetch_ctrl.sv
// Instruction-fetch sequencer: credit-limited memory requests, in-order response
// pairing, instruction FIFO and redirect flush. PREFETCH_PERF_EN adds perf counters.
module prefetch_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUT   = 2,
  parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr_rdata,
  output logic [XLEN-1:0] instr_pc,
  output logic            busy
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]     perf_discard,
  output logic [31:0]     perf_starve
`endif
);

  localparam int FCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUT + 1);
  localparam int DCW = $clog2(MAX_OUT + 2);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_addr_q, hold_addr_d;
  logic            hold_q, hold_d;
  logic            stale_q, stale_d;
  logic [DCW-1:0]  discard_q, discard_d;

  logic [FCW-1:0]  fifo_count;
  logic [OCW-1:0]  outstanding;
  fetch_entry_t    pcq_in, pcq_head, ifq_in, ifq_head;
  logic            gnt_fire, rvalid_ok, credit_ok, ifq_push;
  int              out_next;

  assign gnt_fire  = imem_req && imem_gnt;
  assign rvalid_ok = imem_rvalid && (outstanding != '0);
  assign credit_ok = ((int'(fifo_count) + int'(outstanding) - int'(discard_q)) < DEPTH)
                     && (int'(outstanding) < MAX_OUT);

  // A request left ungranted keeps its address regardless of state or redirect.
  assign imem_req  = hold_q || ((state_q == RUN) && credit_ok);
  assign imem_addr = hold_q ? hold_addr_q : pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    hold_d      = imem_req && !imem_gnt;
    hold_addr_d = imem_addr;
    stale_d     = (imem_req && !imem_gnt) && (stale_q || redirect);
    out_next    = int'(outstanding) + (gnt_fire ? 1 : 0) - (rvalid_ok ? 1 : 0);

    case (state_q)
      IDLE:    if (fetch_en) state_d = RUN;
      RUN:     if (!fetch_en) state_d = HALT;
      HALT: begin
        if (fetch_en)                  state_d = RUN;
        else if (outstanding == '0)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A stale held request was issued for the old stream, so it must not advance pc.
    if (redirect)                               pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (gnt_fire && !(hold_q && stale_q))  pc_d = pc_q + XLEN'(4);

    if (redirect)                               discard_d = DCW'(out_next + (hold_d ? 1 : 0));
    else if (rvalid_ok && (discard_q != '0))    discard_d = discard_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= BOOT_ADDR;
      hold_addr_q <= BOOT_ADDR;
      hold_q      <= 1'b0;
      stale_q     <= 1'b0;
      discard_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
      hold_q      <= hold_d;
      stale_q     <= stale_d;
      discard_q   <= discard_d;
    end
  end

  // Granted addresses, popped in order as responses return; its fill is the outstanding count.
  assign pcq_in = '{instr: '0, pc: imem_addr};

  prefetch_fifo #(.DEPTH(MAX_OUT)) u_pc_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (gnt_fire),
    .push_data (pcq_in),
    .pop       (rvalid_ok),
    .head      (pcq_head),
    .count     (outstanding)
  );

  assign ifq_in   = '{instr: imem_rdata, pc: pcq_head.pc};
  assign ifq_push = rvalid_ok && (discard_q == '0) && !redirect;

  prefetch_fifo #(.DEPTH(DEPTH)) u_instr_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (ifq_push),
    .push_data (ifq_in),
    .pop       (instr_valid && instr_ready),
    .head      (ifq_head),
    .count     (fifo_count)
  );

  assign instr_valid = (fifo_count != '0);
  assign instr_rdata = instr_valid ? ifq_head.instr : '0;
  assign instr_pc    = instr_valid ? ifq_head.pc : '0;
  assign busy        = (outstanding != '0) || instr_valid;

  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], pcq_head.instr};

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_discard_q, perf_starve_q;
  logic        drop_evt, starve_evt;

  assign drop_evt   = rvalid_ok && (redirect || (discard_q != '0));
  assign starve_evt = (state_q == RUN) && !instr_valid && !redirect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_discard_q <= '0;
      perf_starve_q  <= '0;
    end else begin
      if (drop_evt && (perf_discard_q != '1))  perf_discard_q <= perf_discard_q + 1'b1;
      if (starve_evt && (perf_starve_q != '1)) perf_starve_q  <= perf_starve_q + 1'b1;
    end
  end

  assign perf_discard = perf_discard_q;
  assign perf_starve  = perf_starve_q;
`endif

`ifndef SYNTHESIS
  rvalid_needs_outstanding: assert property (
    @(posedge clock) disable iff (reset) imem_rvalid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Directed-vector bench for prefetch_ctrl with an in-order instruction memory responder.
module tb_prefetch_ctrl;
  import riscv_fetch_pkg::*;

  logic        clock, reset, fetch_en, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, busy;
  logic [31:0] instr_rdata, instr_pc;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_discard, perf_starve;
`endif

  logic        gnt_en, rsp_en;
  logic [31:0] mem_a [8];
  logic [2:0]  wr_p, rd_p;
  int          checks = 0;
  int          failures = 0;

  prefetch_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_rdata (instr_rdata),
    .instr_pc    (instr_pc),
    .busy        (busy)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_discard(perf_discard),
    .perf_starve (perf_starve)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: grants combinationally when enabled, answers in order; data = addr ^ DEAD0000.
  assign imem_gnt    = gnt_en && imem_req;
  assign imem_rvalid = rsp_en && (wr_p != rd_p);
  assign imem_rdata  = mem_a[rd_p] ^ 32'hDEAD_0000;

  always @(posedge clock) begin
    if (reset) begin
      wr_p <= '0;
      rd_p <= '0;
    end else begin
      if (imem_req && imem_gnt) begin
        mem_a[wr_p] <= imem_addr;
        wr_p <= wr_p + 3'd1;
      end
      if (imem_rvalid) rd_p <= rd_p + 3'd1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt_en = 1'b0; rsp_en = 1'b0; instr_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt_en = 1'b1; rsp_en = 1'b1; instr_ready = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h80) begin failures++; $display("FAIL rst_addr got=%h exp=00000080", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++; if (instr_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", instr_rdata); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", instr_pc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset = 1'b0;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_idle_req got=%b exp=0", imem_req); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1; instr_ready = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin failures++; $display("FAIL str_addr0 got=%b/%h exp=1/00000080", imem_req, imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h84) begin failures++; $display("FAIL str_addr1 got=%h exp=00000084", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL str_lat got=%b exp=0", instr_valid); end
    tick();
    checks++; if (imem_addr !== 32'h88) begin failures++; $display("FAIL str_addr2 got=%h exp=00000088", imem_addr); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h80) begin failures++; $display("FAIL str_pc0 got=%b/%h exp=1/00000080", instr_valid, instr_pc); end
    checks++; if (instr_rdata !== 32'hDEAD_0080) begin failures++; $display("FAIL str_data0 got=%h exp=dead0080", instr_rdata); end
    tick();
    checks++; if (instr_pc !== 32'h84) begin failures++; $display("FAIL str_pc1 got=%h exp=00000084", instr_pc); end
    tick();
    checks++; if (instr_pc !== 32'h88) begin failures++; $display("FAIL str_pc2 got=%h exp=00000088", instr_pc); end
    $display("test_stream done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_backpressure();
    int ngnt;
    do_reset();
    fetch_en = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1; instr_ready = 1'b0;
    ngnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (imem_req && imem_gnt) ngnt++;
    end
    checks++; if (ngnt != 4) begin failures++; $display("FAIL bp_grants got=%0d exp=4", ngnt); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_off got=%b exp=0", imem_req); end
    checks++; if (instr_pc !== 32'h80 || instr_rdata !== 32'hDEAD_0080) begin failures++; $display("FAIL bp_head got=%h/%h exp=00000080/dead0080", instr_pc, instr_rdata); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h90) begin failures++; $display("FAIL bp_refill got=%b/%h exp=1/00000090", imem_req, imem_addr); end
    checks++; if (instr_pc !== 32'h84) begin failures++; $display("FAIL bp_head2 got=%h exp=00000084", instr_pc); end
    $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_held_redirect();
    do_reset();
    fetch_en = 1'b1; gnt_en = 1'b0; rsp_en = 1'b1; instr_ready = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin failures++; $display("FAIL hold_c1 got=%b/%h exp=1/00000080", imem_req, imem_addr); end
    tick();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin failures++; $display("FAIL hold_c3 got=%b/%h exp=1/00000080", imem_req, imem_addr); end
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin failures++; $display("FAIL hold_post_redir got=%b/%h exp=1/00000080", imem_req, imem_addr); end
    gnt_en = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL hold_newaddr got=%b/%h exp=1/00000200", imem_req, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL hold_drop got=%b exp=0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin failures++; $display("FAIL hold_first got=%b/%h exp=1/00000200", instr_valid, instr_pc); end
    checks++; if (instr_rdata !== 32'hDEAD_0200) begin failures++; $display("FAIL hold_data got=%h exp=dead0200", instr_rdata); end
    $display("test_held_redirect done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    fetch_en = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0; instr_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ro_maxout got=%b exp=0", imem_req); end
    redirect = 1'b1; redirect_pc = 32'h0000_1000; rsp_en = 1'b1;
    tick();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ro_flush got=%b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin failures++; $display("FAIL ro_newaddr got=%b/%h exp=1/00001000", imem_req, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ro_drop2 got=%b exp=0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1000) begin failures++; $display("FAIL ro_first got=%b/%h exp=1/00001000", instr_valid, instr_pc); end
    checks++; if (instr_rdata !== 32'hDEAD_1000) begin failures++; $display("FAIL ro_data got=%h exp=dead1000", instr_rdata); end
    $display("test_redirect_outstanding done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_halt();
    do_reset();
    fetch_en = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0; instr_ready = 1'b0;
    tick();
    tick();
    tick();
    fetch_en = 1'b0;
    tick();
    checks++; if (dut.state_q !== HALT) begin failures++; $display("FAIL halt_enter got=%0d exp=%0d", dut.state_q, HALT); end
    checks++; if (imem_req !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL halt_req_busy got=%b/%b exp=0/1", imem_req, busy); end
    rsp_en = 1'b1;
    tick();
    tick();
    checks++; if (dut.state_q !== HALT) begin failures++; $display("FAIL halt_wait got=%0d exp=%0d", dut.state_q, HALT); end
    tick();
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL halt_idle got=%0d exp=%0d", dut.state_q, IDLE); end
    checks++; if (busy !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL halt_busy got=%b/%b exp=1/0", busy, imem_req); end
    checks++; if (instr_pc !== 32'h80) begin failures++; $display("FAIL halt_head got=%h exp=00000080", instr_pc); end
    instr_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b1 || instr_pc !== 32'h84) begin failures++; $display("FAIL halt_drain1 got=%b/%h exp=1/00000084", busy, instr_pc); end
    tick();
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL halt_drained got=%b/%b exp=0/0", busy, instr_valid); end
    $display("test_halt done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_midflight();
    bit seen;
    do_reset();
    fetch_en = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0; instr_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_pre got=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h80) begin failures++; $display("FAIL mid_req got=%b/%h exp=0/00000080", imem_req, imem_addr); end
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b/%b exp=0/0", busy, instr_valid); end
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (imem_req) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL mid_restart_timeout got=0 exp=1"); end
    checks++; if (imem_addr !== 32'h80) begin failures++; $display("FAIL mid_restart_addr got=%h exp=00000080", imem_addr); end
    $display("test_reset_midflight done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_held_redirect();
    test_redirect_outstanding();
    test_halt();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
